// File: rtl/dvi_out_pkg.sv
// Shared constants for the DVI colour-bar streamer: default 640x480@60 timing,
// counter widths and the 8-bar RGB888 palette.
package dvi_out_pkg;

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // White, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] BAR_COLOURS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/dvi_out_streamer_timing_gen.sv
// Word-phase, pixel and line counters for the DVI streamer, with active/sync decode
// taken combinationally from the current counter state.
module dvi_timing_gen
    import dvi_out_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic             iClk,
    input  logic             iRstN,
    output logic             oPhase,
    output logic             oActive,
    output logic             oHs,
    output logic             oVs,
    output logic [CNT_W-1:0] oHCnt
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             r_phase;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;

    // Pixel counters only move on the second word of each pixel.
    always_comb begin
        w_h_next = r_h_cnt;
        w_v_next = r_v_cnt;
        if (r_phase) begin
            if (r_h_cnt == H_LAST) begin
                w_h_next = '0;
                w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_ONE;
            end else begin
                w_h_next = r_h_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_phase <= 1'b0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_phase <= ~r_phase;
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
        end
    end

    always_comb begin
        oActive = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        oHs     = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
        oVs     = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
    end

    assign oPhase = r_phase;
    assign oHCnt  = r_h_cnt;

endmodule

// File: rtl/dvi_out_streamer.sv
// Self-contained DVI source: 8-bar colour pattern sent as two 12-bit words per pixel
// ({G[3:0],B} then {R,G[7:4]}) on a clock running at twice the pixel rate.
module dvi_out_streamer
    import dvi_out_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic        iClk,
    input  logic        iRstN,
    output logic [11:0] oData,
    output logic        oHsync,
    output logic        oVsync,
    output logic        oDe
);

    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

    logic             w_phase;
    logic             w_active;
    logic             w_hs;
    logic             w_vs;
    logic [CNT_W-1:0] w_h_cnt;
    logic [2:0]       w_bar;
    logic [23:0]      w_rgb;
    logic [11:0]      w_word;

    logic [11:0]      r_data;
    logic             r_de;
    logic             r_hsync;
    logic             r_vsync;

    dvi_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .iClk    (iClk),
        .iRstN   (iRstN),
        .oPhase  (w_phase),
        .oActive (w_active),
        .oHs     (w_hs),
        .oVs     (w_vs),
        .oHCnt   (w_h_cnt)
    );

    // Bar index is only meaningful inside the active region; data is gated outside it.
    always_comb begin
        w_bar  = 3'(w_h_cnt / BAR_W);
        w_rgb  = BAR_COLOURS[w_bar];
        w_word = w_phase ? {w_rgb[23:16], w_rgb[15:12]} : {w_rgb[11:8], w_rgb[7:0]};
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_data  <= '0;
            r_de    <= 1'b0;
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
        end else begin
            r_data  <= w_active ? w_word : 12'h000;
            r_de    <= w_active;
            r_hsync <= w_hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync <= w_vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    assign oData  = r_data;
    assign oDe    = r_de;
    assign oHsync = r_hsync;
    assign oVsync = r_vsync;

endmodule

// File: tb/tb_dvi_out_streamer.sv
// Bench for dvi_out_streamer: default-timing instance for pixel/line checks and a
// shrunken-timing instance (active-high syncs) for whole-frame checks.
module tb_dvi_out_streamer;

    localparam int SHA = 16, SHFP = 2, SHS = 3, SHBP = 3;
    localparam int SVA = 4, SVFP = 1, SVS = 2, SVBP = 1;
    localparam bit SSA = 1'b1;
    localparam int S_HT = SHA + SHFP + SHS + SHBP;
    localparam int S_VT = SVA + SVFP + SVS + SVBP;
    localparam int CAP_D = 3300;
    localparam int CAP_S = 2 * S_HT * S_VT * 2 + 64;

    logic        clk = 1'b0;
    logic        rst_d_n;
    logic        rst_s_n;
    logic [11:0] d_data, s_data;
    logic        d_hs, d_vs, d_de, s_hs, s_vs, s_de;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_d   = 0;
    int cnt_s   = 0;
    bit cap_d_on = 1'b1;
    bit cap_s_on = 1'b1;

    logic [14:0] cap_d [CAP_D];
    logic [1:0]  cap_s [CAP_S];
    logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 clk = ~clk;

    dvi_out_streamer dut (
        .iClk   (clk),
        .iRstN  (rst_d_n),
        .oData  (d_data),
        .oHsync (d_hs),
        .oVsync (d_vs),
        .oDe    (d_de)
    );

    dvi_out_streamer #(
        .H_ACTIVE (SHA), .H_FP (SHFP), .H_SYNC (SHS), .H_BP (SHBP),
        .V_ACTIVE (SVA), .V_FP (SVFP), .V_SYNC (SVS), .V_BP (SVBP),
        .SYNC_ACTIVE (SSA)
    ) dut_s (
        .iClk   (clk),
        .iRstN  (rst_s_n),
        .oData  (s_data),
        .oHsync (s_hs),
        .oVsync (s_vs),
        .oDe    (s_de)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected {de, hsync, vsync, data} for the t-th output word after reset release.
    function automatic logic [14:0] ref_out(input int t, input int ha, input int hfp,
                                            input int hs, input int hbp, input int va,
                                            input int vfp, input int vs, input int vbp,
                                            input bit sa);
        int ht, vt, p, h, v;
        logic act, hsy, vsy;
        logic [23:0] c;
        logic [11:0] w;
        ht  = ha + hfp + hs + hbp;
        vt  = va + vfp + vs + vbp;
        p   = t / 2;
        h   = p % ht;
        v   = (p / ht) % vt;
        act = (h < ha) && (v < va);
        hsy = (h >= ha + hfp) && (h < ha + hfp + hs);
        vsy = (v >= va + vfp) && (v < va + vfp + vs);
        w   = 12'h000;
        if (act) begin
            c = bar_rgb[h / (ha / 8)];
            w = (t % 2 == 0) ? {c[11:8], c[7:0]} : {c[23:16], c[15:12]};
        end
        return {act, hsy ? sa : ~sa, vsy ? sa : ~sa, w};
    endfunction

    always @(posedge clk or negedge rst_d_n)
        if (!rst_d_n) cnt_d <= 0;
        else          cnt_d <= cnt_d + 1;

    always @(posedge clk or negedge rst_s_n)
        if (!rst_s_n) cnt_s <= 0;
        else          cnt_s <= cnt_s + 1;

    always @(negedge clk) begin
        if (!rst_d_n || cnt_d == 0) begin
            check_eq("d_reset", {17'd0, d_de, d_hs, d_vs, d_data}, {17'd0, 15'h3000});
        end else begin
            check_eq("d_word", {17'd0, d_de, d_hs, d_vs, d_data},
                     {17'd0, ref_out(cnt_d - 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)});
            if (cap_d_on && cnt_d - 1 < CAP_D) cap_d[cnt_d - 1] <= {d_de, d_hs, d_vs, d_data};
        end
        if (!rst_s_n || cnt_s == 0) begin
            check_eq("s_reset", {17'd0, s_de, s_hs, s_vs, s_data},
                     {17'd0, 1'b0, ~SSA, ~SSA, 12'h000});
        end else begin
            check_eq("s_word", {17'd0, s_de, s_hs, s_vs, s_data},
                     {17'd0, ref_out(cnt_s - 1, SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP, SSA)});
            if (cap_s_on && cnt_s - 1 < CAP_S) cap_s[cnt_s - 1] <= {s_de, s_vs};
        end
    end

    initial begin
        int de_rise0, de_rise1, de_fall0, hs_fall0, hs_rise0;
        int vs_start0, vs_end0, vs_start1, de_blank, de_frame;
        logic [14:0] cur, prv;
        rst_d_n = 1'b1;
        rst_s_n = 1'b1;
        #1;
        rst_d_n = 1'b0;
        rst_s_n = 1'b0;
        repeat ($urandom_range(3, 8)) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_hold", {17'd0, d_de, d_hs, d_vs, d_data}, {17'd0, 15'h3000});

        // Default-timing instance: first lines, then a mid-line asynchronous reset.
        #($urandom_range(1, 3));
        rst_d_n = 1'b1;
        repeat (CAP_D + 2) @(posedge clk);
        cap_d_on = 1'b0;
        #1;
        check_eq("first_clk", {17'd0, cap_d[0]}, {17'd0, 15'h7FFF});
        check_eq("second_clk", {20'd0, cap_d[1][11:0]}, 32'hFFF);
        check_eq("px79_w0", {20'd0, cap_d[158][11:0]}, 32'hFFF);
        check_eq("px79_w1", {20'd0, cap_d[159][11:0]}, 32'hFFF);
        check_eq("px80_w0", {20'd0, cap_d[160][11:0]}, 32'hF00);
        check_eq("px80_w1", {20'd0, cap_d[161][11:0]}, 32'hFFF);
        check_eq("px160_w0", {20'd0, cap_d[320][11:0]}, 32'hFFF);
        check_eq("px160_w1", {20'd0, cap_d[321][11:0]}, 32'h00F);
        check_eq("px600_black", {19'd0, cap_d[1200][14], cap_d[1200][11:0]}, 32'h1000);
        check_eq("px645_blank", {19'd0, cap_d[1290][14], cap_d[1290][11:0]}, 32'h0);
        check_eq("px700_blank", {19'd0, cap_d[1400][14], cap_d[1400][11:0]}, 32'h0);

        de_rise0 = -1; de_rise1 = -1; de_fall0 = -1; hs_fall0 = -1; hs_rise0 = -1;
        for (int i = 0; i < CAP_D; i++) begin
            cur = cap_d[i];
            prv = (i == 0) ? 15'h3000 : cap_d[i - 1];
            if (cur[14] && !prv[14]) begin
                if (de_rise0 < 0) de_rise0 = i;
                else if (de_rise1 < 0) de_rise1 = i;
            end
            if (!cur[14] && prv[14] && de_fall0 < 0) de_fall0 = i;
            if (!cur[13] && prv[13] && hs_fall0 < 0) hs_fall0 = i;
            if (cur[13] && !prv[13] && hs_fall0 >= 0 && hs_rise0 < 0) hs_rise0 = i;
        end
        check_eq("de_run", de_fall0 - de_rise0, 1280);
        check_eq("line_period", de_rise1 - de_rise0, 1600);
        check_eq("hs_start", hs_fall0 - de_rise0, 1312);
        check_eq("hs_width", hs_rise0 - hs_fall0, 192);

        repeat ($urandom_range(100, 2000)) @(posedge clk);
        #($urandom_range(1, 3));
        rst_d_n = 1'b0;
        #1;
        check_eq("d_async_rst", {17'd0, d_de, d_hs, d_vs, d_data}, {17'd0, 15'h3000});
        repeat ($urandom_range(1, 4)) @(posedge clk);
        @(negedge clk);
        #($urandom_range(1, 3));
        rst_d_n = 1'b1;
        repeat (400) @(posedge clk);

        // Small-timing instance: two whole frames, then a mid-frame reset.
        @(negedge clk);
        #($urandom_range(1, 3));
        rst_s_n = 1'b1;
        repeat (CAP_S + 2) @(posedge clk);
        cap_s_on = 1'b0;
        #1;
        vs_start0 = -1; vs_end0 = -1; vs_start1 = -1; de_blank = 0; de_frame = 0;
        for (int i = 0; i < CAP_S; i++) begin
            logic a, pa;
            a  = (cap_s[i][0] == SSA);
            pa = (i == 0) ? 1'b0 : (cap_s[i - 1][0] == SSA);
            if (a && !pa) begin
                if (vs_start0 < 0) vs_start0 = i;
                else if (vs_start1 < 0) vs_start1 = i;
            end
            if (!a && pa && vs_start0 >= 0 && vs_end0 < 0) vs_end0 = i;
            if (cap_s[i][1] && ((i / 2) / S_HT) % S_VT >= SVA) de_blank++;
            if (cap_s[i][1] && i < 2 * S_HT * S_VT) de_frame++;
        end
        check_eq("vs_start", vs_start0, 2 * S_HT * (SVA + SVFP));
        check_eq("vs_width", vs_end0 - vs_start0, 2 * S_HT * SVS);
        check_eq("frame_period", vs_start1 - vs_start0, 2 * S_HT * S_VT);
        check_eq("de_in_vblank", de_blank, 0);
        check_eq("de_per_frame", de_frame, 2 * SHA * SVA);

        repeat (2 * S_HT * (SVA / 2) + $urandom_range(0, 2 * S_HT - 1)) @(posedge clk);
        #($urandom_range(1, 3));
        rst_s_n = 1'b0;
        #1;
        check_eq("s_async_rst", {17'd0, s_de, s_hs, s_vs, s_data},
                 {17'd0, 1'b0, ~SSA, ~SSA, 12'h000});
        repeat ($urandom_range(1, 4)) @(posedge clk);
        @(negedge clk);
        #($urandom_range(1, 3));
        rst_s_n = 1'b1;
        repeat (2 * S_HT * S_VT + 20) @(posedge clk);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dvi_out_streamer.md
Name: dvi_out_streamer

Overview:
- Self-contained DVI source for a Chrontel-style 12-bit double-data-rate transmitter interface.
- Generates 640x480@60 video timing and an 8-bar colour test pattern.
- Emits each 24-bit pixel as two consecutive 12-bit words on one clock running at twice the pixel rate.
- Sits directly before the board output pins and the transmitter; it has no pixel input.

Parameters:
- H_ACTIVE, 640, active pixels per line (must be a multiple of 8)
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_ACTIVE, 0, asserted level of oHsync/oVsync (0 = active-low)

Ports:
- iClk  in  1  word clock; one clock, 2x pixel rate (50.35 MHz nominal)
- iRstN  in  1  asynchronous active-low reset
- oData  out  12  transmitter data word
- oHsync  out  1  horizontal sync
- oVsync  out  1  vertical sync
- oDe  out  1  data enable (active pixel)

Behaviour:
- Reset (iRstN=0, asynchronous, any time including mid-frame):
  - phase=0, hCnt=0, vCnt=0.
  - oData=0, oDe=0, oHsync=oVsync=~SYNC_ACTIVE.
  - Counting restarts at pixel (0,0) after release.
- Phase bit toggles every iClk.
- hCnt advances on clocks where phase=1.
  - hCnt range is 0..H_TOTAL-1, with H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - When hCnt=H_TOTAL-1 and phase=1: hCnt wraps to 0 and vCnt advances.
- vCnt range is 0..V_TOTAL-1, with V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - vCnt wraps to 0 on the last pixel of line V_TOTAL-1, so the frame restarts.
- Frame length = 2*800*525 = 840000 clocks.
- Decode from the current counters:
  - active = (hCnt<H_ACTIVE) && (vCnt<V_ACTIVE)
  - hs = H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vs = V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC (490..491)
- Pattern: bar = hCnt/(H_ACTIVE/8), giving 80 px per bar.
  - Bar 0..7 colours, RGB888: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - The pattern is independent of vCnt.
- Word mux for pixel {R,G,B}:
  - phase 0 word = {G[3:0],B[7:0]}
  - phase 1 word = {R[7:0],G[7:4]}
  - oData=0 whenever the pixel is not active.
- All outputs are registered, with 1 iClk latency from the counter state.
  - oDe, oHsync and oVsync are held identical across both words of a pixel, changing only on phase-0 words.
- First clock after reset release: oDe=1, oData=12'hFFF, syncs inactive.
- No handshake: free-running.
- Sync polarity is applied only at the output register.

Decomposition:
- Package dvi_out_pkg:
  - default 640x480 timing constants
  - H_TOTAL/V_TOTAL computation helpers
  - 24-bit colour bar constants (8-entry array)
  - counter width localparams (10 bits each)
- Sub-module dvi_timing_gen:
  - owns phase, hCnt and vCnt counters
  - outputs active/hs/vs/hCnt
- Top level owns bar lookup, word mux and output registers.

Test Plan:
- Reset held then released:
  - during reset: oData=0, oDe=0, oHsync=oVsync=1
  - 1st clock after release: oDe=1, oData=FFF
  - 2nd clock: oData=FFF
- Bar edge on line 0: pixel 79 (clocks 158/159) gives FFF/FFF; pixel 80 (yellow) gives F00/FFF; pixel 160 (cyan) gives FFF/00F.
- Line timing:
  - oDe high for exactly 1280 consecutive clocks per active line.
  - oHsync low for 192 clocks starting at clock offset 1312 after line start.
  - Line period 1600 clocks.
- Frame timing:
  - oVsync low for exactly 3200 clocks, starting at line 490.
  - oDe never high on lines 480..524.
  - Frame period 840000 clocks.
- Black bar and blanking: pixel 600 gives oData=000 with oDe=1; blanking pixels give oData=000 with oDe=0.
- Mid-frame reset (e.g. at line 300): outputs go to reset values immediately (asynchronously); after release the sequence matches the first-frame start exactly.
